// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - raster pixel stream to registered 3x3 neighbourhood windows
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int X_BITS     = $clog2(IMG_WIDTH),
  parameter int Y_BITS     = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [`WORD_SIZE-1:0] in_pixel,
  output logic [`WORD_SIZE-1:0] p1,
  output logic [`WORD_SIZE-1:0] p2,
  output logic [`WORD_SIZE-1:0] p3,
  output logic [`WORD_SIZE-1:0] p4,
  output logic [`WORD_SIZE-1:0] p5,
  output logic [`WORD_SIZE-1:0] p6,
  output logic [`WORD_SIZE-1:0] p7,
  output logic [`WORD_SIZE-1:0] p8,
  output logic [`WORD_SIZE-1:0] p9,
  output logic                  out_valid,
  output logic [X_BITS-1:0]     out_x,
  output logic [Y_BITS-1:0]     out_y
);

  localparam int W = `WORD_SIZE;

  logic [X_BITS-1:0] x, pos_x, next_x;
  logic [Y_BITS-1:0] y, pos_y, next_y;
  logic              accept;
  logic [W-1:0]      lb0 [IMG_WIDTH];
  logic [W-1:0]      lb1 [IMG_WIDTH];
  logic [W-1:0]      lb0_rd, lb1_rd;

  always_comb begin
    accept = en & in_valid;
    pos_x  = in_sof ? '0 : x;
    pos_y  = in_sof ? '0 : y;
    next_x = (pos_x == X_BITS'(IMG_WIDTH - 1)) ? '0 : pos_x + 1'b1;
    next_y = pos_y;
    if (pos_x == X_BITS'(IMG_WIDTH - 1))
      next_y = (pos_y == Y_BITS'(IMG_HEIGHT - 1)) ? '0 : pos_y + 1'b1;
    lb0_rd = lb0[pos_x];
    lb1_rd = lb1[pos_x];
  end

  // Line buffers carry no reset; rows 0/1 are masked by the y>=2 gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pos_x] <= lb0_rd;
      lb0[pos_x] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
      p4        <= '0;
      p5        <= '0;
      p6        <= '0;
      p7        <= '0;
      p8        <= '0;
      p9        <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (en) begin
      out_valid <= accept & (pos_x >= X_BITS'(2)) & (pos_y >= Y_BITS'(2));
      if (in_valid) begin
        x     <= next_x;
        y     <= next_y;
        p1    <= p2;
        p2    <= p3;
        p3    <= lb1_rd;
        p4    <= p5;
        p5    <= p6;
        p6    <= lb0_rd;
        p7    <= p8;
        p8    <= p9;
        p9    <= in_pixel;
        out_x <= pos_x - 1'b1;
        out_y <= pos_y - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - scoreboard bench for window_3x3_gen on a 4x4 frame
module tb_window_3x3_gen;

  localparam int IW = 4;
  localparam int IH = 4;

  typedef struct packed {
    logic [1:0]      x;
    logic [1:0]      y;
    logic [8:0][7:0] p;
  } win_t;

  logic       clk = 1'b0;
  logic       reset_n, en, in_valid, in_sof;
  logic [7:0] in_pixel;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       out_valid;
  logic [1:0] out_x, out_y;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y)
  );

  win_t exp_q[$];
  win_t seen_q[$];
  win_t last_win, mon_act, mon_exp;
  int   vectors = 0;
  int   miscompares = 0;
  logic en_at_edge = 1'b0;
  logic valid_at_edge = 1'b0;

  always @(posedge clk) begin
    en_at_edge    <= en;
    valid_at_edge <= in_valid;
  end

  function automatic win_t make_win(int cx, int cy, int base);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w.p[r*3+c] = 8'(base + 16*(cy-1+r) + (cx-1+c));
    w.x = 2'(cx);
    w.y = 2'(cy);
    return w;
  endfunction

  function automatic win_t dut_win();
    win_t w;
    w.p = {p9, p8, p7, p6, p5, p4, p3, p2, p1};
    w.x = out_x;
    w.y = out_y;
    return w;
  endfunction

  task automatic check(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a held window during a stall must match the last one emitted.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      mon_act = dut_win();
      vectors++;
      if (!en_at_edge) begin
        if (mon_act !== last_win) begin
          miscompares++;
          $display("FAIL stall_hold: got %h, expected %h", mon_act, last_win);
        end
      end else begin
        seen_q.push_back(mon_act);
        if (!valid_at_edge) begin
          miscompares++;
          $display("FAIL valid_after_idle: got out_valid=1, expected 0");
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_window: got %h, expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          last_win = mon_exp;
          if (mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL window: got x=%0d y=%0d p=%h, expected x=%0d y=%0d p=%h",
                     mon_act.x, mon_act.y, mon_act.p, mon_exp.x, mon_exp.y, mon_exp.p);
          end
        end
      end
    end
  end

  task automatic send_frame(int base, bit sof, bit gap, int stall_x, int stall_y, int npix);
    for (int i = 0; i < npix; i++) begin
      int px, py;
      px = i % IW;
      py = i / IW;
      @(posedge clk); #1;
      en       = 1'b1;
      in_valid = 1'b1;
      in_sof   = sof && (i == 0);
      in_pixel = 8'(base + 16*py + px);
      if (px >= 2 && py >= 2) exp_q.push_back(make_win(px-1, py-1, base));
      if (px == stall_x && py == stall_y) begin
        @(posedge clk); #1;
        en       = 1'b0;
        in_sof   = 1'b1;
        in_pixel = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        en       = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end else if (gap) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic check_frame(string name, int n0, int expn);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk); #1;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_count"}, seen_q.size() - n0, expn);
  endtask

  int hand[9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
  int n0;

  initial begin
    reset_n = 1'b1; en = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_x", int'(out_x), 0);
    check("reset_out_y", int'(out_y), 0);
    check("reset_p5", int'(p5), 0);
    check("reset_p9", int'(p9), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    n0 = seen_q.size();
    send_frame(0, 1, 0, -1, -1, 16);
    check_frame("cont", n0, 4);
    if (seen_q.size() >= n0 + 4) begin
      for (int i = 0; i < 9; i++)
        check($sformatf("first_p%0d", i+1), int'(seen_q[n0].p[i]), hand[i]);
      check("first_x", int'(seen_q[n0].x), 1);
      check("first_y", int'(seen_q[n0].y), 1);
      check("last_p1", int'(seen_q[n0+3].p[0]), 8'h11);
      check("last_p9", int'(seen_q[n0+3].p[8]), 8'h33);
      check("last_x", int'(seen_q[n0+3].x), 2);
      check("last_y", int'(seen_q[n0+3].y), 2);
    end

    n0 = seen_q.size();
    send_frame(0, 1, 0, 2, 2, 16);
    check_frame("stall", n0, 4);
    if (seen_q.size() >= n0 + 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("stall_vs_cont%0d", k), int'(seen_q[n0+k] === seen_q[k]), 1);

    n0 = seen_q.size();
    send_frame(0, 1, 1, -1, -1, 16);
    check_frame("gap", n0, 4);

    n0 = seen_q.size();
    send_frame(8'h40, 1, 0, -1, -1, 6);
    send_frame(0, 1, 0, -1, -1, 16);
    check_frame("restart", n0, 4);

    n0 = seen_q.size();
    send_frame(8'h40, 1, 0, -1, -1, 11);
    check_frame("pre_reset", n0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_p1", int'(p1), 0);
    check("midreset_p5", int'(p5), 0);
    check("midreset_p9", int'(p9), 0);
    check("midreset_out_x", int'(out_x), 0);
    check("midreset_out_y", int'(out_y), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    n0 = seen_q.size();
    send_frame(0, 0, 0, -1, -1, 16);
    send_frame(0, 0, 0, -1, -1, 16);
    check_frame("two_frames", n0, 8);
    if (seen_q.size() >= n0 + 8)
      check("second_frame_first_win", int'(seen_q[n0] === seen_q[n0+4]), 1);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Raster-to-window producer feeding the 3x3 neighbourhood consumers, such as the Sobel window stage.
- Accepts one pixel per cycle in raster order.
- Keeps the two previous image rows in internal line buffers.
- Emits a registered 3x3 window (p1..p9, same layout as the consumers) for every interior centre pixel, with a valid strobe and the centre coordinates.

Parameters:
- IMG_WIDTH, 640, pixels per row; minimum 3.
- IMG_HEIGHT, 480, rows per frame; minimum 3.
- X_BITS, $clog2(IMG_WIDTH), width of column counter and out_x.
- Y_BITS, $clog2(IMG_HEIGHT), width of row counter and out_y.
- Pixel width is `WORD_SIZE from global.vh.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  global pipeline enable; low = full stall.
- in_valid  in  1  in_pixel is valid this cycle.
- in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame.
- in_pixel  in  `WORD_SIZE  raster pixel.
- p1..p9  out  `WORD_SIZE each  window registers; p1 top-left, p5 centre, p9 bottom-right.
- out_valid  out  1  window on p1..p9 is new this cycle.
- out_x  out  X_BITS  centre column.
- out_y  out  Y_BITS  centre row.

Behaviour:
- Reset (async, reset_n=0):
  - x=0, y=0.
  - p1..p9=0, out_valid=0, out_x=0, out_y=0.
  - Line buffer contents are not reset and are don't-care.
- accept = en & in_valid.
- en=0: every register, counter and line buffer holds; out_valid holds its value. in_valid is ignored.
- Position of accepted pixel: (0,0) if in_sof=1, else the current (x,y) counters.
- Counter update on accept:
  - x = pos_x+1, or 0 when pos_x = IMG_WIDTH-1.
  - y advances at the same point; y wraps to 0 after IMG_HEIGHT-1, so back-to-back frames need no in_sof.
- Line buffers: lb0 holds row y-1, lb1 holds row y-2; IMG_WIDTH words each, indexed by pos_x. On accept, at the same edge:
  - Read lb1[pos_x] and lb0[pos_x] (old contents).
  - Write lb1[pos_x] <= lb0[pos_x] and lb0[pos_x] <= in_pixel.
- Window shift on accept:
  - Left column takes the old middle column: p1<=p2, p4<=p5, p7<=p8.
  - Middle column takes the old right column: p2<=p3, p5<=p6, p8<=p9.
  - New right column: p3<=lb1[pos_x], p6<=lb0[pos_x], p9<=in_pixel.
- Output qualification:
  - out_valid <= accept & (pos_x>=2) & (pos_y>=2).
  - out_x <= pos_x-1, out_y <= pos_y-1, loaded on every accept.
  - en=1 with in_valid=0: out_valid <= 0; window and coordinates hold.
- Latency: window centred (cx,cy) appears one cycle after pixel (cx+1,cy+1) is accepted.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) out_valid pulses per frame. Border centres are never emitted; the downstream stage fills the border.
- Cross-row stale columns (at x=0,1) and stale/unreset line data (rows 0,1) are never exposed, because of the x>=2 / y>=2 gating.
- in_sof mid-frame: position forced to (0,0) and the frame restarts. No out_valid until row 2, col 2 of the new frame.
- Async reset mid-frame: same as power-up. The first accepted pixel after release is (0,0) regardless of in_sof.
- Simultaneous en=0 and in_sof=1: no effect; the stall wins.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, pixel=16*y+x, in_valid=1 continuously, in_sof on the first pixel.
  - Cycle after pixel 0x22 is accepted: out_valid=1, out_x=1, out_y=1, p1..p9 = 00,01,02,10,11,12,20,21,22.
  - Cycle after 0x33: centre (2,2), p1=0x11, p9=0x33.
- Same 4x4 frame: exactly 4 out_valid pulses, centres (1,1),(2,1),(1,2),(2,2), none for pixels in rows 0-1 or cols 0-1.
- Assert en=0 for 3 cycles right after 0x22 is presented: out_valid stays 1 and p1..p9 unchanged; resume gives the identical sequence to the unstalled run.
- in_valid gaps (1 idle cycle between every pixel): same windows and coordinates as the continuous run; out_valid=0 on the cycle after each idle.
- Send 6 pixels, then in_sof=1 with 0x00: counters restart, the first out_valid follows pixel (2,2) of the new frame, with no window mixing the old frame's rows.
- Pull reset_n low mid-row 2: outputs go to 0 immediately (asynchronous, no clock edge). Then two full 4x4 frames back-to-back without in_sof: 4 valid windows each, and the second frame's (1,1) window equals the first's.
